// File: rtl/buffer_reader.sv
// Burst reader: fetches words 0..LAST_ADDR from a synchronous memory and presents each one
// downstream over a valid/ready handshake, pulsing done once the last word is accepted.
module buffer_reader #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned LAST_ADDR = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              mem_rd_en,
    output logic [3:0]        mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [3:0] LastAddr = 4'(LAST_ADDR);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLatch,
        StHold,
        StDone
    } state_e;

    state_e     state_q;
    logic [3:0] addr_q;

    assign mem_raddr = addr_q;

    // All outputs except mem_raddr are registered; each is set on the edge entering the state
    // in which it must be high, so its value always matches the current state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            addr_q    <= 4'd0;
            mem_rd_en <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            mem_rd_en <= 1'b0;
            done      <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q   <= StFetch;
                        addr_q    <= 4'd0;
                        mem_rd_en <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                StFetch: begin
                    state_q <= StLatch;
                end
                StLatch: begin
                    // Memory data is valid in this cycle, one after the read strobe.
                    out_data  <= mem_rdata;
                    out_valid <= 1'b1;
                    state_q   <= StHold;
                end
                StHold: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (addr_q == LastAddr) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                        end else begin
                            addr_q    <= addr_q + 4'd1;
                            state_q   <= StFetch;
                            mem_rd_en <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q   <= StIdle;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_buffer_reader.sv
// Directed bench for buffer_reader: memory model returns 0xA0+addr, a negedge monitor logs
// read strobes, accepted words and done pulses, and each scenario checks against fixed values.
module tb_buffer_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       out_ready;
    logic       mem_rd_en;
    logic [3:0] mem_raddr;
    logic [7:0] mem_rdata = 8'h00;
    logic [7:0] out_data;
    logic       out_valid;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [3:0] rd_q[$];
    logic [7:0] acc_q[$];
    int done_n, t_fetch0, t_done, t_hs, t_start;

    always #5 clk = ~clk;

    buffer_reader #(
        .DATA_W   (8),
        .LAST_ADDR(10)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mem_rd_en(mem_rd_en),
        .mem_raddr(mem_raddr),
        .mem_rdata(mem_rdata),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .done     (done)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= 8'hA0 + 8'(mem_raddr);
    end

    always @(negedge clk) begin
        if (mem_rd_en) begin
            rd_q.push_back(mem_raddr);
            if (t_fetch0 < 0) t_fetch0 = cyc;
        end
        if (out_valid && out_ready) begin
            acc_q.push_back(out_data);
            t_hs = cyc;
        end
        if (done) begin
            done_n++;
            if (t_done < 0) t_done = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        rd_q.delete();
        acc_q.delete();
        done_n   = 0;
        t_fetch0 = -1;
        t_done   = -1;
        t_hs     = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"}, mem_rd_en, 0);
        check({tag, "_raddr"}, mem_raddr, 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    task automatic check_bursts(input string tag, input int nb);
        int bad = 0;
        check({tag, "_n_words"}, acc_q.size(), 11 * nb);
        check({tag, "_n_reads"}, rd_q.size(), 11 * nb);
        foreach (acc_q[i]) if (acc_q[i] !== 8'hA0 + 8'(i % 11)) bad++;
        foreach (rd_q[i]) if (rd_q[i] !== 4'(i % 11)) bad++;
        check({tag, "_order"}, bad, 0);
        check({tag, "_dones"}, done_n, nb);
    endtask

    // Called at a drive point; issues a one-cycle start and runs until nb done pulses plus a tail.
    task automatic run(input int stall_word, input int stall_n, input bit poke, input int nb);
        int left = stall_n;
        int dones = 0;
        int tail = 0;
        bit b2b_pend = 1'b0;
        clear_log();
        t_start   = cyc;
        start     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 400 && tail < 4; i++) begin
            cycle();
            start     = 1'b0;
            out_ready = 1'b1;
            if (b2b_pend) begin
                start    = 1'b1;
                b2b_pend = 1'b0;
            end
            if (left > 0 && left < stall_n) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, 8'hA0 + 8'(stall_word));
                check("stall_rd_en", mem_rd_en, 0);
                check("stall_busy", busy, 1);
                out_ready = 1'b0;
                left--;
            end else if (stall_n > 0 && left == stall_n && out_valid &&
                         out_data == 8'hA0 + 8'(stall_word)) begin
                out_ready = 1'b0;
                left--;
            end
            if (poke && out_valid && out_data == 8'hA5) start = 1'b1;
            if (done) begin
                dones++;
                if (poke) start = 1'b1;
                if (dones < nb) b2b_pend = 1'b1;
            end
            if (dones == nb) tail++;
        end
        check("run_complete", dones, nb);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        reset     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        clear_log();
        #3;
        check_reset_outputs("reset");
        cycle();
        cycle();

        // Basic burst; start is raised together with reset release.
        reset = 1'b1;
        run(0, 0, 1'b0, 1);
        check_bursts("basic", 1);
        check("basic_fetch_lat", t_fetch0 - t_start, 1);
        check("basic_fetch_to_done", t_done - t_fetch0, 33);
        check("basic_hs_to_done", t_done - t_hs, 1);
        check("basic_idle_busy", busy, 0);

        // Downstream stall on word 3.
        run(3, 5, 1'b0, 1);
        check_bursts("stall", 1);

        // start pulses during HOLD of word 5 and during DONE are ignored.
        run(0, 0, 1'b1, 1);
        check_bursts("poke", 1);
        check("poke_idle_busy", busy, 0);
        check("poke_idle_rd_en", mem_rd_en, 0);

        // Asynchronous reset between edges during word 6.
        clear_log();
        start     = 1'b1;
        out_ready = 1'b1;
        found     = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            cycle();
            start = 1'b0;
            if (out_valid && out_data == 8'hA6) found = 1'b1;
        end
        check("rst_reach_word6", found, 1);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        cycle();
        cycle();
        cycle();
        check("midrst_no_done", done_n, 0);
        reset = 1'b1;
        run(0, 0, 1'b0, 1);
        check("midrst_first_addr", rd_q.size() > 0 ? 32'(rd_q[0]) : 32'hFFFF, 0);
        check_bursts("after_rst", 1);

        // Back-to-back bursts.
        run(0, 0, 1'b0, 2);
        check_bursts("b2b", 2);
        check("b2b_idle_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
